// File: rtl/aoi221_bist_ctrl.sv
// aoi221_bist_ctrl: exhaustive-sweep BIST controller for an AOI221 cell.
// Drives all 32 input vectors, samples ZN and reports pass/fail results.
module aoi221_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ZN_IN,
   output logic       A1,
   output logic       A2,
   output logic       B1,
   output logic       B2,
   output logic       C,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] FAIL_CNT,
   output logic [4:0] FIRST_FAIL,
   output logic       FAIL_SEEN,
   inout  wire        VDD,
   inout  wire        VSS
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
   localparam logic [2:0] LP_PLAST  = 3'(PASSES - 1);

   logic [1:0] r_state;
   logic [4:0] r_v;
   logic [2:0] r_p;
   logic [3:0] r_s;
   logic [7:0] r_fail_cnt;
   logic [4:0] r_first_fail;
   logic       r_fail_seen;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_exp;
   logic       w_mis;
   logic [7:0] w_cnt_upd;

   // Supply pins carry no logic; tie them off into an unused net.
   wire w_unused_supply = VDD ^ VSS;

   // Golden AOI221 response for the vector currently driven.
   assign w_exp = ~((r_v[0] & r_v[1]) | (r_v[2] & r_v[3]) | r_v[4]);
   assign w_mis = (ZN_IN != w_exp);

   // Failure count after this sample, saturating at 255.
   assign w_cnt_upd = (w_mis && r_fail_cnt != 8'hFF) ? r_fail_cnt + 8'd1
                                                      : r_fail_cnt;

   // Run sequencing, vector sweep and result capture.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_v          <= '0;
         r_p          <= '0;
         r_s          <= '0;
         r_fail_cnt   <= '0;
         r_first_fail <= '0;
         r_fail_seen  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  r_state      <= ST_HOLD;
                  r_v          <= '0;
                  r_p          <= '0;
                  r_s          <= '0;
                  r_fail_cnt   <= '0;
                  r_first_fail <= '0;
                  r_fail_seen  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (r_s < LP_SETTLE) begin
                  r_s <= r_s + 4'd1;
               end else begin
                  r_s        <= '0;
                  r_fail_cnt <= w_cnt_upd;
                  if (w_mis && !r_fail_seen) begin
                     r_first_fail <= r_v;
                     r_fail_seen  <= 1'b1;
                  end
                  if (r_v != 5'd31) begin
                     r_v <= r_v + 5'd1;
                  end else if (r_p != LP_PLAST) begin
                     r_v <= '0;
                     r_p <= r_p + 3'd1;
                  end else begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_cnt_upd == 8'd0);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stimulus comes straight from the vector register.
   assign A1         = r_v[0];
   assign A2         = r_v[1];
   assign B1         = r_v[2];
   assign B2         = r_v[3];
   assign C          = r_v[4];
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign PASS       = r_pass;
   assign FAIL_CNT   = r_fail_cnt;
   assign FIRST_FAIL = r_first_fail;
   assign FAIL_SEEN  = r_fail_seen;

endmodule
